apb_timer_regs: RTL and testbench

- APB completer (responder) and register file for the 8-bit timer. Terminates PSEL/PENABLE/PWRITE/PADDR/PWDATA transfers from the APB bus driver.
- Holds TCR/TDR/TSR, exposes TCNT read-only, and drives control fields to the counter core.
- Sticky OVF/UDF flags are set by counter-core pulses and cleared by write-1-to-clear.

---
 rtl/apb_timer_regs.sv | 123 ++++++++++++
 tb/tb_apb_timer_regs.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/apb_timer_regs.sv
// APB completer and register file for the 8-bit timer: TCR/TDR/TSR storage, TCNT readback,
// sticky overflow/underflow flags with write-1-to-clear, and optional access-phase wait states.
module apb_timer_regs #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] tcnt_i,
  input  logic                  ovf_set_i,
  input  logic                  udf_set_i,
  output logic [DATA_WIDTH-1:0] tdr_o,
  output logic                  tcr_load_o,
  output logic                  tcr_updown_o,
  output logic                  tcr_en_o,
  output logic [1:0]            tcr_cks_o,
  output logic                  tmr_ovf_o,
  output logic                  tmr_udf_o
);

  localparam logic [3:0]            WaitMax = 4'(WAIT_STATES);
  // Implemented TCR bits: 7 (load), 5 (updown), 4 (en), 1:0 (cks).
  localparam logic [DATA_WIDTH-1:0] TcrMask = DATA_WIDTH'(8'hB3);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                state;
  logic [3:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] tcr;
  logic [DATA_WIDTH-1:0] tdr;
  logic [1:0]            tsr;

  logic                  in_access;
  logic                  complete;
  logic                  addr_valid;
  logic                  wr_tcr;
  logic                  wr_tdr;
  logic                  wr_tsr;
  logic [1:0]            tsr_clr;
  logic [1:0]            tsr_set;
  logic [DATA_WIDTH-1:0] rd_mux;

  always_comb begin
    in_access  = (state == StAccess) && PSEL && PENABLE;
    complete   = in_access && (wait_cnt == WaitMax);
    addr_valid = PADDR < ADDR_WIDTH'(4);

    wr_tcr = complete && PWRITE && (PADDR == ADDR_WIDTH'(0));
    wr_tdr = complete && PWRITE && (PADDR == ADDR_WIDTH'(1));
    wr_tsr = complete && PWRITE && (PADDR == ADDR_WIDTH'(2));

    tsr_clr = wr_tsr ? PWDATA[1:0] : 2'b00;
    tsr_set = {udf_set_i, ovf_set_i};

    rd_mux = '0;
    case (PADDR)
      ADDR_WIDTH'(0): rd_mux = tcr;
      ADDR_WIDTH'(1): rd_mux = tdr;
      ADDR_WIDTH'(2): rd_mux = DATA_WIDTH'(tsr);
      ADDR_WIDTH'(3): rd_mux = tcnt_i;
      default:        rd_mux = '0;
    endcase

    PREADY  = in_access ? (wait_cnt == WaitMax) : 1'b1;
    PSLVERR = complete && !addr_valid;
    PRDATA  = (complete && !PWRITE && addr_valid) ? rd_mux : '0;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state    <= StIdle;
      wait_cnt <= '0;
      tcr      <= '0;
      tdr      <= '0;
      tsr      <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            state    <= StAccess;
            wait_cnt <= '0;
          end
        end
        StAccess: begin
          if (!PSEL) begin
            state <= StIdle;
          end else if (!PENABLE) begin
            // A fresh setup phase restarts the wait count.
            wait_cnt <= '0;
          end else if (complete) begin
            state <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= StIdle;
      endcase

      if (wr_tcr) tcr <= PWDATA & TcrMask;
      if (wr_tdr) tdr <= PWDATA;
      // Set wins over a simultaneous clear.
      tsr <= (tsr & ~tsr_clr) | tsr_set;
    end
  end

  assign tdr_o        = tdr;
  assign tcr_load_o   = tcr[7];
  assign tcr_updown_o = tcr[5];
  assign tcr_en_o     = tcr[4];
  assign tcr_cks_o    = tcr[1:0];
  assign tmr_ovf_o    = tsr[0];
  assign tmr_udf_o    = tsr[1];

endmodule

// File: tb/tb_apb_timer_regs.sv
// Bench for apb_timer_regs: two instances (0 and 2 wait states) share one APB bus and are
// checked every cycle against a register-level model of the timer's address map.
module tb_apb_timer_regs;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0, tcnt = '0;
  logic ovf = 1'b0, udf = 1'b0;

  logic [1:0][7:0] prdata, tdr;
  logic [1:0][1:0] cks;
  logic [1:0] pready, pslverr, load, updown, en, ovf_o, udf_o;

  int checks = 0;
  int failures = 0;
  int ws [2] = '{0, 2};
  bit rand_flags = 1'b0;

  logic [7:0] m_tcr [2];
  logic [7:0] m_tdr [2];
  logic [7:0] m_tsr [2];

  always #5 clk = ~clk;

  apb_timer_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .tcnt_i(tcnt), .ovf_set_i(ovf), .udf_set_i(udf),
    .tdr_o(tdr[0]), .tcr_load_o(load[0]), .tcr_updown_o(updown[0]), .tcr_en_o(en[0]),
    .tcr_cks_o(cks[0]), .tmr_ovf_o(ovf_o[0]), .tmr_udf_o(udf_o[0])
  );

  apb_timer_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESETn(rstn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .tcnt_i(tcnt), .ovf_set_i(ovf), .udf_set_i(udf),
    .tdr_o(tdr[1]), .tcr_load_o(load[1]), .tcr_updown_o(updown[1]), .tcr_en_o(en[1]),
    .tcr_cks_o(cks[1]), .tmr_ovf_o(ovf_o[1]), .tmr_udf_o(udf_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input int d);
    case (paddr)
      8'h00:   return m_tcr[d];
      8'h01:   return m_tdr[d];
      8'h02:   return m_tsr[d];
      8'h03:   return tcnt;
      default: return 8'h00;
    endcase
  endfunction

  // Register-level effect of one clock edge on each instance.
  function automatic void model_edge(input bit [1:0] comp);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] clr;
      clr = 8'h00;
      if (!rstn) begin
        m_tcr[d] = 8'h00;
        m_tdr[d] = 8'h00;
        m_tsr[d] = 8'h00;
      end else begin
        if (comp[d] && pwrite) begin
          case (paddr)
            8'h00:   m_tcr[d] = pwdata & 8'hB3;
            8'h01:   m_tdr[d] = pwdata;
            8'h02:   clr = pwdata & 8'h03;
            default: ;
          endcase
        end
        m_tsr[d] = (m_tsr[d] & ~clr) | {6'b0, udf, ovf};
      end
    end
  endfunction

  task automatic run_cycle(input bit [1:0] comp, input bit [1:0] exp_ready);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic [7:0] exp_rd;
      bit valid;
      valid  = paddr < 8'h04;
      exp_rd = (comp[d] && !pwrite && valid) ? model_read(d) : 8'h00;
      check_eq($sformatf("dut%0d.pready", ws[d]), 32'(pready[d]), 32'(exp_ready[d]));
      check_eq($sformatf("dut%0d.prdata a=%0h", ws[d], paddr), 32'(prdata[d]), 32'(exp_rd));
      check_eq($sformatf("dut%0d.pslverr", ws[d]), 32'(pslverr[d]), 32'(comp[d] && !valid));
      check_eq($sformatf("dut%0d.tdr_o", ws[d]), 32'(tdr[d]), 32'(m_tdr[d]));
      check_eq($sformatf("dut%0d.tcr_fields", ws[d]),
               32'({load[d], updown[d], en[d], cks[d]}),
               32'({m_tcr[d][7], m_tcr[d][5], m_tcr[d][4], m_tcr[d][1:0]}));
      check_eq($sformatf("dut%0d.flags", ws[d]), 32'({udf_o[d], ovf_o[d]}),
               32'(m_tsr[d][1:0]));
    end
    @(posedge clk);
    model_edge(comp);
    #1;
  endtask

  task automatic drive_flags(input bit force_udf);
    tcnt = 8'($urandom);
    ovf  = rand_flags && ($urandom_range(0, 5) == 0);
    udf  = force_udf || (rand_flags && ($urandom_range(0, 5) == 0));
  endtask

  task automatic idle(input bit o, input bit u);
    psel = 1'b0; penable = 1'b0;
    drive_flags(1'b0);
    ovf = ovf | o;
    udf = udf | u;
    run_cycle(2'b00, 2'b11);
    ovf = 1'b0; udf = 1'b0;
  endtask

  // The access phase is held until the slower instance completes; the faster one sees the
  // extra cycles as enable-without-setup, which must have no effect.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      input bit force_udf, input bit rst_mid);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    drive_flags(1'b0);
    run_cycle(2'b00, 2'b11);
    penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bit [1:0] comp, rdy;
      drive_flags(force_udf);
      if (rst_mid) rstn = 1'b0;
      for (int d = 0; d < 2; d++) begin
        comp[d] = (k == ws[d]);
        rdy[d]  = (k >= ws[d]);
      end
      run_cycle(comp, rdy);
      if (rst_mid) begin
        rstn = 1'b1;
        break;
      end
    end
    psel = 1'b0; penable = 1'b0; ovf = 1'b0; udf = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    @(posedge clk);
    model_edge(2'b00);
    #1;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    rstn = 1'b1;

    for (int a = 0; a < 4; a++) xfer(1'b0, 8'(a), 8'h00, 1'b0, 1'b0);

    xfer(1'b1, 8'h01, 8'hA5, 1'b0, 1'b0);
    xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    idle(1'b1, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 8'h02, 8'hFF, 1'b0, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);

    idle(1'b0, 1'b1);
    xfer(1'b1, 8'h02, 8'h02, 1'b1, 1'b0);
    xfer(1'b0, 8'h02, 8'h00, 1'b0, 1'b0);

    xfer(1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 8'h5A, 1'b0, 1'b0);
    xfer(1'b1, 8'h03, 8'h99, 1'b0, 1'b0);
    xfer(1'b1, 8'h01, 8'h3C, 1'b0, 1'b0);

    xfer(1'b1, 8'h01, 8'h77, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    xfer(1'b1, 8'h01, 8'h42, 1'b0, 1'b0);
    xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0);

    rand_flags = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] addr;
      addr = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      xfer(1'($urandom), addr, 8'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
